// File: rtl/uncached_dbus_bridge.sv
// Uncached data-bus bridge: turns kseg1 dbus requests into single-beat cbus
// transactions, with an optional one-entry posted-write buffer for MMIO stores.
module uncached_dbus_bridge #(
    parameter bit POSTED_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [3:0]  dreq_strobe,
    input  logic [31:0] dreq_data,
    input  logic        uncached,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [31:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [31:0] creq_addr,
    output logic [3:0]  creq_strobe,
    output logic [31:0] creq_data,
    output logic [3:0]  creq_len,
    output logic [1:0]  creq_burst,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [31:0] cresp_data,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [3:0] MLEN1           = 4'd0;
    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [31:0] addr_r;
    logic [2:0]  size_r;
    logic [3:0]  strobe_r;
    logic [31:0] data_r;
    logic        is_write_r;
    logic [31:0] rdata_r;

    logic accept_s;
    logic wr_s;
    logic posted_s;
    logic done_s;
    logic issuing_s;

    assign wr_s      = (dreq_strobe != 4'd0);
    assign accept_s  = (state_r == IDLE) && dreq_valid && uncached;
    assign posted_s  = POSTED_WRITE && wr_s;
    // Only ready together with last completes the single beat; ready alone holds.
    assign done_s    = cresp_ready && cresp_last;
    assign issuing_s = (state_r == REQ) || (state_r == DRAIN);

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = posted_s ? DRAIN : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (done_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = REQ;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            DRAIN: begin
                if (done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, request-field capture and read-data capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            addr_r     <= 32'd0;
            size_r     <= 3'd0;
            strobe_r   <= 4'd0;
            data_r     <= 32'd0;
            is_write_r <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                addr_r     <= dreq_addr;
                size_r     <= dreq_size;
                strobe_r   <= dreq_strobe;
                data_r     <= dreq_data;
                is_write_r <= wr_s;
            end
            if ((state_r == REQ) && done_s) begin
                rdata_r <= is_write_r ? 32'd0 : cresp_data;
            end
        end
    end

    // A posted write is acknowledged in its accept cycle, independent of cresp.
    assign dresp_addr_ok = accept_s;
    assign dresp_data_ok = (accept_s && posted_s) || (state_r == RESP);
    assign dresp_data    = (state_r == RESP) ? rdata_r : 32'd0;

    assign creq_valid    = issuing_s;
    assign creq_is_write = issuing_s && is_write_r;
    assign creq_size     = issuing_s ? size_r : 3'd0;
    assign creq_addr     = issuing_s ? addr_r : 32'd0;
    assign creq_strobe   = issuing_s ? strobe_r : 4'd0;
    assign creq_data     = issuing_s ? data_r : 32'd0;
    assign creq_len      = issuing_s ? MLEN1 : 4'd0;
    assign creq_burst    = issuing_s ? AXI_BURST_FIXED : 2'd0;

    assign busy = (state_r != IDLE);
endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Scoreboard bench for uncached_dbus_bridge: instance 0 is blocking-only,
// instance 1 has the posted-write buffer enabled.
module tb_uncached_dbus_bridge;
    typedef struct {
        int          inst;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          inst;
        logic [77:0] fields;
    } creq_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dreq_valid[2];
    logic [31:0] dreq_addr[2];
    logic [2:0]  dreq_size[2];
    logic [3:0]  dreq_strobe[2];
    logic [31:0] dreq_data[2];
    logic        uncached[2];
    logic        dresp_addr_ok[2];
    logic        dresp_data_ok[2];
    logic [31:0] dresp_data[2];
    logic        creq_valid[2];
    logic        creq_is_write[2];
    logic [2:0]  creq_size[2];
    logic [31:0] creq_addr[2];
    logic [3:0]  creq_strobe[2];
    logic [31:0] creq_data[2];
    logic [3:0]  creq_len[2];
    logic [1:0]  creq_burst[2];
    logic        cresp_ready[2];
    logic        cresp_last[2];
    logic [31:0] cresp_data[2];
    logic        busy[2];

    resp_t resp_q[$];
    creq_t creq_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall[2];
    int nolast[2];
    int cnt[2];
    int dok_cyc[2];
    int dok_prev[2];
    int cq_first[2];
    int cq_done[2];
    logic cv_prev[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uncached_dbus_bridge #(.POSTED_WRITE(g == 1)) u_dut (
            .clk           (clk),
            .resetn        (resetn),
            .dreq_valid    (dreq_valid[g]),
            .dreq_addr     (dreq_addr[g]),
            .dreq_size     (dreq_size[g]),
            .dreq_strobe   (dreq_strobe[g]),
            .dreq_data     (dreq_data[g]),
            .uncached      (uncached[g]),
            .dresp_addr_ok (dresp_addr_ok[g]),
            .dresp_data_ok (dresp_data_ok[g]),
            .dresp_data    (dresp_data[g]),
            .creq_valid    (creq_valid[g]),
            .creq_is_write (creq_is_write[g]),
            .creq_size     (creq_size[g]),
            .creq_addr     (creq_addr[g]),
            .creq_strobe   (creq_strobe[g]),
            .creq_data     (creq_data[g]),
            .creq_len      (creq_len[g]),
            .creq_burst    (creq_burst[g]),
            .cresp_ready   (cresp_ready[g]),
            .cresp_last    (cresp_last[g]),
            .cresp_data    (cresp_data[g]),
            .busy          (busy[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        case (a)
            32'h1FD0_03F8: return 32'h0000_00A5;
            32'h1FD0_0000: return 32'h1111_2222;
            32'h1FD0_0004: return 32'h3333_4444;
            default:       return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [77:0] pack_creq(input logic w, input logic [2:0] sz,
                                              input logic [3:0] st, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] len,
                                              input logic [1:0] bu);
        return {w, sz, st, a, d, len, bu};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Memory/arbiter model: ready after stall[i] cycles of valid, last after nolast[i] more
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!resetn || !creq_valid[i]) begin
                    cnt[i]         = 0;
                    cresp_ready[i] = 1'b0;
                    cresp_last[i]  = 1'b0;
                    cresp_data[i]  = 32'd0;
                end else begin
                    cnt[i]         = cnt[i] + 1;
                    cresp_ready[i] = (cnt[i] > stall[i]);
                    cresp_last[i]  = (cnt[i] == stall[i] + 1 + nolast[i]);
                    cresp_data[i]  = cresp_ready[i] ? rd_data(creq_addr[i]) : 32'd0;
                end
            end
        end
    end

    // Monitor: pops expected responses and cbus requests as the DUT presents them
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (dresp_data_ok[i]) begin
                    dok_prev[i] = dok_cyc[i];
                    dok_cyc[i]  = cyc;
                    if (resp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_data_ok inst %0d data 0x%0h", i, dresp_data[i]));
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_inst", i, r.inst);
                        chk("resp_data", dresp_data[i], r.data);
                    end
                end
                if (creq_valid[i]) begin
                    if (!cv_prev[i]) cq_first[i] = cyc;
                    if (creq_q.size() == 0) begin
                        fail_now($sformatf("unexpected_creq inst %0d addr 0x%0h", i, creq_addr[i]));
                    end else begin
                        chk("creq_inst", i, creq_q[0].inst);
                        chk("creq_fields",
                            pack_creq(creq_is_write[i], creq_size[i], creq_strobe[i], creq_addr[i],
                                      creq_data[i], creq_len[i], creq_burst[i]),
                            creq_q[0].fields);
                        if (cresp_ready[i] && cresp_last[i]) begin
                            cq_done[i] = cyc;
                            void'(creq_q.pop_front());
                        end
                    end
                end
                cv_prev[i] = creq_valid[i];
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] exp_data,
                         output int acc, output logic dok0);
        resp_t r;
        creq_t c;
        int n = 0;
        r.inst   = i;
        r.data   = exp_data;
        c.inst   = i;
        c.fields = pack_creq(s != 4'd0, 3'd2, s, a, d, 4'd0, 2'd0);
        resp_q.push_back(r);
        creq_q.push_back(c);
        @(posedge clk);
        #1;
        dreq_valid[i]  = 1'b1;
        uncached[i]    = 1'b1;
        dreq_addr[i]   = a;
        dreq_strobe[i] = s;
        dreq_data[i]   = d;
        dreq_size[i]   = 3'd2;
        @(negedge clk);
        while (!dresp_addr_ok[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("accept_timeout");
        acc  = cyc;
        dok0 = dresp_data_ok[i];
    endtask

    task automatic drop(input int i);
        @(posedge clk);
        #1;
        dreq_valid[i] = 1'b0;
    endtask

    task automatic at_cyc(input int t);
        do @(negedge clk); while (cyc < t);
        if (cyc != t) fail_now("at_cyc_overshoot");
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((resp_q.size() != 0 || creq_q.size() != 0 || busy[0] || busy[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int   acc;
        int   acc2;
        logic dok0;
        for (int i = 0; i < 2; i++) begin
            dreq_valid[i]  = 1'b0;
            dreq_addr[i]   = 32'd0;
            dreq_size[i]   = 3'd0;
            dreq_strobe[i] = 4'd0;
            dreq_data[i]   = 32'd0;
            uncached[i]    = 1'b0;
            stall[i]       = 0;
            nolast[i]      = 0;
            dok_cyc[i]     = -1;
            dok_prev[i]    = -1;
            cq_first[i]    = -1;
            cq_done[i]     = -1;
            cv_prev[i]     = 1'b0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_addr_ok", dresp_addr_ok[i], 1'b0);
            chk("rst_data_ok", dresp_data_ok[i], 1'b0);
            chk("rst_dresp_data", dresp_data[i], 32'd0);
            chk("rst_creq_valid", creq_valid[i], 1'b0);
            chk("rst_creq_addr", creq_addr[i], 32'd0);
            chk("rst_busy", busy[i], 1'b0);
        end
        resetn = 1'b1;

        // Blocking read with a two-cycle arbiter stall
        stall[0] = 2;
        issue(0, 32'h1FD0_03F8, 4'h0, 32'h0, 32'h0000_00A5, acc, dok0);
        chk("rd_dok_at_accept", dok0, 1'b0);
        drop(0);
        wait_drain();
        chk("rd_creq_first", cq_first[0], acc + 1);
        chk("rd_creq_done", cq_done[0], acc + 3);
        chk("rd_dok_cycle", dok_cyc[0], acc + 4);

        // Blocking write on the non-posted instance returns data 0
        stall[0] = 1;
        issue(0, 32'h1FD0_0010, 4'hF, 32'hCAFE_F00D, 32'h0, acc, dok0);
        chk("bw_dok_at_accept", dok0, 1'b0);
        drop(0);
        wait_drain();
        chk("bw_creq_done", cq_done[0], acc + 2);
        chk("bw_dok_cycle", dok_cyc[0], acc + 3);

        // Posted write completes in its accept cycle, drains in the background
        stall[1] = 0;
        issue(1, 32'h1FAF_F000, 4'b0001, 32'h0000_0055, 32'h0, acc, dok0);
        chk("pw_dok_at_accept", dok0, 1'b1);
        chk("pw_dok_cycle", dok_cyc[1], acc);
        drop(1);
        at_cyc(acc + 1);
        chk("pw_busy_drain", busy[1], 1'b1);
        at_cyc(acc + 2);
        chk("pw_busy_idle", busy[1], 1'b0);
        wait_drain();
        chk("pw_creq_done", cq_done[1], acc + 1);

        // Posted write followed at once by a read; arbiter stalls 5 cycles each
        stall[1] = 5;
        issue(1, 32'h1FAF_F000, 4'b0001, 32'h0000_0055, 32'h0, acc, dok0);
        chk("wr_rd_w_dok", dok0, 1'b1);
        issue(1, 32'h1FAF_F004, 4'h0, 32'h0, 32'hC102_4EEB, acc2, dok0);
        chk("wr_rd_r_dok_at_accept", dok0, 1'b0);
        drop(1);
        chk("wr_rd_accept_gap", acc2 - acc, 32'd7);
        wait_drain();
        chk("wr_rd_r_creq_first", cq_first[1], acc2 + 1);
        chk("wr_rd_r_dok_cycle", dok_cyc[1], acc2 + 7);

        // Cached request is ignored
        @(posedge clk);
        #1;
        dreq_valid[0]  = 1'b1;
        uncached[0]    = 1'b0;
        dreq_addr[0]   = 32'h0000_1000;
        dreq_strobe[0] = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cached_addr_ok", dresp_addr_ok[0], 1'b0);
            chk("cached_data_ok", dresp_data_ok[0], 1'b0);
            chk("cached_data", dresp_data[0], 32'd0);
            chk("cached_creq_valid", creq_valid[0], 1'b0);
            chk("cached_busy", busy[0], 1'b0);
        end
        drop(0);

        // ready without last must not complete the transaction
        stall[0]  = 0;
        nolast[0] = 2;
        issue(0, 32'h1FD0_0000, 4'h0, 32'h0, 32'h1111_2222, acc, dok0);
        drop(0);
        wait_drain();
        chk("nolast_creq_done", cq_done[0], acc + 3);
        chk("nolast_dok_cycle", dok_cyc[0], acc + 4);
        nolast[0] = 0;

        // Reset while the request is on the bus
        stall[0] = 10;
        issue(0, 32'h1FD0_0100, 4'h0, 32'h0, 32'h0, acc, dok0);
        drop(0);
        at_cyc(acc + 1);
        chk("rstmid_creq_before", creq_valid[0], 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rstmid_creq_valid", creq_valid[0], 1'b0);
        chk("rstmid_busy", busy[0], 1'b0);
        resp_q.delete();
        creq_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        stall[0] = 1;
        issue(0, 32'h1FD0_0004, 4'h0, 32'h0, 32'h3333_4444, acc, dok0);
        drop(0);
        wait_drain();
        chk("rstmid_after_dok_cycle", dok_cyc[0], acc + 3);

        // Back-to-back blocking reads, arbiter answers in the first cycle
        stall[0] = 0;
        issue(0, 32'h1FD0_0000, 4'h0, 32'h0, 32'h1111_2222, acc, dok0);
        issue(0, 32'h1FD0_0004, 4'h0, 32'h0, 32'h3333_4444, acc2, dok0);
        drop(0);
        chk("b2b_accept_gap", acc2 - acc, 32'd3);
        wait_drain();
        chk("b2b_dok_gap", dok_cyc[0] - dok_prev[0], 32'd3);
        chk("b2b_second_dok_cycle", dok_cyc[0], acc2 + 2);

        repeat (2) @(negedge clk);
        chk("final_resp_q_empty", resp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
